// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared state encoding, reset values and parameter legality for rst_seq_ctrl
package rst_seq_pkg;
  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2,
    SW_RST  = 2'd3
  } seq_state_t;
  localparam seq_state_t STATE_RST = HOLD;
  localparam logic OUT_RST_N = 1'b0;
  function automatic bit params_ok(int n_out, int hold_cyc, int step_cyc, int cnt_w);
    return n_out >= 1 && n_out <= 8 && hold_cyc >= 1 && step_cyc >= 1 &&
           cnt_w >= 1 && cnt_w <= 31 &&
           (hold_cyc - 1) < (1 << cnt_w) && (step_cyc - 1) < (1 << cnt_w);
  endfunction
endpackage

// File: rtl/rst_sync_2ff.sv
// rst_sync_2ff: async-assert, sync-release two-flop reset synchronizer
module rst_sync_2ff (
  input  logic clk,
  input  logic rst_n,
  output logic rst_sync_n
);
  logic meta;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {rst_sync_n, meta} <= 2'b00;
    else {rst_sync_n, meta} <= {meta, 1'b1};
endmodule

// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: sequenced downstream reset release with soft re-sequence request
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int N_OUT    = 3,
  parameter int HOLD_CYC = 16,
  parameter int STEP_CYC = 8,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sw_rst_req,
  output logic             sw_rst_ack,
  output logic [N_OUT-1:0] rst_out_n,
  output logic             seq_done,
  output logic [1:0]       seq_state
);
  if (!params_ok(N_OUT, HOLD_CYC, STEP_CYC, CNT_W)) begin : g_bad_params
    $error("rst_seq_ctrl: illegal parameter combination");
  end
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYC - 1);
  localparam logic [2:0]       IDX_LAST  = 3'(N_OUT - 1);
  logic             rst_sync_n;
  seq_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  rst_sync_2ff u_sync (.clk(clk), .rst_n(rst_n), .rst_sync_n(rst_sync_n));
  assign seq_state = state;
  always_ff @(posedge clk or negedge rst_sync_n)
    if (!rst_sync_n) begin
      state      <= STATE_RST;
      cnt        <= '0;
      idx        <= '0;
      rst_out_n  <= {N_OUT{OUT_RST_N}};
      seq_done   <= 1'b0;
      sw_rst_ack <= 1'b0;
    end else begin
      case (state)
        HOLD:
          if (cnt == HOLD_LAST) begin
            state <= RELEASE;
            cnt   <= '0;
            idx   <= '0;
          end else cnt <= cnt + 1'b1;
        RELEASE:
          if (cnt == STEP_LAST) begin
            cnt       <= '0;
            idx       <= idx + 1'b1;
            rst_out_n <= rst_out_n | (N_OUT'(1) << idx);
            if (idx == IDX_LAST) begin
              state    <= RUN;
              seq_done <= 1'b1;
            end
          end else cnt <= cnt + 1'b1;
        RUN:
          if (sw_rst_req) begin
            state      <= SW_RST;
            rst_out_n  <= '0;
            seq_done   <= 1'b0;
            sw_rst_ack <= 1'b1;
          end
        SW_RST:
          if (!sw_rst_req) begin
            state      <= HOLD;
            cnt        <= '0;
            sw_rst_ack <= 1'b0;
          end
      endcase
    end
endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb_rst_seq_ctrl: directed and random checks of rst_seq_ctrl against a timeline model
module tb_rst_seq_ctrl;
  localparam int HOLD = 4;
  localparam int STEP = 2;
  localparam int NA   = 3;
  localparam int NB   = 1;
  localparam int TOT_A = HOLD + NA * STEP;
  localparam int TOT_B = HOLD + NB * STEP;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sw_rst_req = 1'b0;
  logic req_b = 1'b0;
  logic ack_a, ack_b, done_a, done_b;
  logic [NA-1:0] out_a;
  logic [NB-1:0] out_b;
  logic [1:0] st_a, st_b;

  int checks = 0;
  int errors = 0;

  // model: edges counted since the sequence (re)started, plus soft-reset flag
  int sync_cnt = 0;
  int k_a = 0;
  int k_b = 0;
  bit sw_a = 1'b0;

  rst_seq_ctrl #(.N_OUT(NA), .HOLD_CYC(HOLD), .STEP_CYC(STEP), .CNT_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .sw_rst_req(sw_rst_req), .sw_rst_ack(ack_a),
    .rst_out_n(out_a), .seq_done(done_a), .seq_state(st_a));

  rst_seq_ctrl #(.N_OUT(NB), .HOLD_CYC(HOLD), .STEP_CYC(STEP), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .sw_rst_req(req_b), .sw_rst_ack(ack_b),
    .rst_out_n(out_b), .seq_done(done_b), .seq_state(st_b));

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync_cnt = 0;
      k_a = 0;
      k_b = 0;
      sw_a = 1'b0;
    end else if (sync_cnt < 2) sync_cnt++;
    else begin
      if (sw_a) begin
        if (!sw_rst_req) begin
          sw_a = 1'b0;
          k_a = 0;
        end
      end else if (k_a >= TOT_A && sw_rst_req) sw_a = 1'b1;
      else if (k_a < 1000) k_a++;
      if (k_b < 1000) k_b++;
    end

  function automatic logic [7:0] exp_out(int k, bit sw, int n);
    logic [7:0] v = '0;
    for (int i = 0; i < n; i++) v[i] = !sw && k >= HOLD + (i + 1) * STEP;
    return v;
  endfunction

  function automatic logic [1:0] exp_state(int k, bit sw, int tot);
    return sw ? 2'd3 : k >= tot ? 2'd2 : k >= HOLD ? 2'd1 : 2'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".a.out"}, 32'(out_a), 32'(exp_out(k_a, sw_a, NA)));
    chk({tag, ".a.done"}, 32'(done_a), 32'(!sw_a && k_a >= TOT_A));
    chk({tag, ".a.ack"}, 32'(ack_a), 32'(sw_a));
    chk({tag, ".a.state"}, 32'(st_a), 32'(exp_state(k_a, sw_a, TOT_A)));
    chk({tag, ".b.out"}, 32'(out_b), 32'(exp_out(k_b, 1'b0, NB)));
    chk({tag, ".b.done"}, 32'(done_b), 32'(k_b >= TOT_B));
    chk({tag, ".b.ack"}, 32'(ack_b), 32'd0);
    chk({tag, ".b.state"}, 32'(st_b), 32'(exp_state(k_b, 1'b0, TOT_B)));
  endtask

  task automatic edges(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_all(tag);
    end
  endtask

  initial begin
    // power-on
    edges(5, "por_low");
    chk("por_low.out", 32'(out_a), 32'd0);
    chk("por_low.state", 32'(st_a), 32'd0);
    rst_n = 1'b1;
    edges(5, "por");
    chk("por_e5.state", 32'(st_a), 32'd0);
    edges(1, "por");
    chk("por_e6.state", 32'(st_a), 32'd1);
    edges(1, "por");
    chk("por_e7.b_out", 32'(out_b), 32'd0);
    edges(1, "por");
    chk("por_e8.out", 32'(out_a), 32'b001);
    chk("por_e8.b_out", 32'(out_b), 32'd1);
    chk("por_e8.b_done", 32'(done_b), 32'd1);
    edges(2, "por");
    chk("por_e10.out", 32'(out_a), 32'b011);
    edges(1, "por");
    chk("por_e11.done", 32'(done_a), 32'd0);
    edges(1, "por");
    chk("por_e12.out", 32'(out_a), 32'b111);
    chk("por_e12.done", 32'(done_a), 32'd1);
    chk("por_e12.state", 32'(st_a), 32'd2);
    edges(2, "run");
    // soft reset, request held three cycles
    sw_rst_req = 1'b1;
    edges(1, "sw");
    chk("sw_f0.out", 32'(out_a), 32'd0);
    chk("sw_f0.ack", 32'(ack_a), 32'd1);
    chk("sw_f0.state", 32'(st_a), 32'd3);
    edges(2, "sw");
    sw_rst_req = 1'b0;
    edges(1, "sw");
    chk("sw_f3.ack", 32'(ack_a), 32'd0);
    chk("sw_f3.state", 32'(st_a), 32'd0);
    edges(5, "sw");
    chk("sw_f8.out", 32'(out_a), 32'd0);
    edges(1, "sw");
    chk("sw_f9.out", 32'(out_a), 32'b001);
    edges(4, "sw");
    chk("sw_f13.out", 32'(out_a), 32'b111);
    // mid-sequence async reset after bit 0 released
    rst_n = 1'b0;
    edges(2, "mid_low");
    rst_n = 1'b1;
    edges(9, "mid");
    #2 rst_n = 1'b0;
    #1;
    chk("mid_async.out", 32'(out_a), 32'd0);
    chk("mid_async.done", 32'(done_a), 32'd0);
    chk("mid_async.b_out", 32'(out_b), 32'd0);
    edges(3, "mid_low");
    rst_n = 1'b1;
    edges(8, "mid_rel");
    chk("mid_e8.out", 32'(out_a), 32'b001);
    edges(4, "mid_rel");
    chk("mid_e12.out", 32'(out_a), 32'b111);
    // early request from HOLD onward
    rst_n = 1'b0;
    edges(2, "early_low");
    rst_n = 1'b1;
    sw_rst_req = 1'b1;
    edges(12, "early");
    chk("early_e12.state", 32'(st_a), 32'd2);
    chk("early_e12.ack", 32'(ack_a), 32'd0);
    edges(1, "early");
    chk("early_e13.state", 32'(st_a), 32'd3);
    chk("early_e13.ack", 32'(ack_a), 32'd1);
    sw_rst_req = 1'b0;
    edges(12, "early_rel");
    // half-period glitch while in RUN
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("glitch.out", 32'(out_a), 32'd0);
    chk("glitch.done", 32'(done_a), 32'd0);
    chk("glitch.state", 32'(st_a), 32'd0);
    #4 rst_n = 1'b1;
    edges(8, "glitch");
    chk("glitch_e8.out", 32'(out_a), 32'b001);
    edges(4, "glitch");
    chk("glitch_e12.out", 32'(out_a), 32'b111);
    // random requests and short reset pulses
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) sw_rst_req = ~sw_rst_req;
      if ($urandom_range(0, 79) == 0) begin
        #2 rst_n = 1'b0;
        #1 check_all("rnd_pulse");
        #1 rst_n = 1'b1;
      end
      edges(1, "rnd");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
